// File: rtl/fp_unpack_pipe.sv
// IEEE-754 operand-pair unpacker: splits A and B into sign, exponent, significand
// with explicit hidden bit and class code, behind a 2-entry skid buffer.
module fp_unpack_pipe #(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MAN_W      = 23,
    parameter bit          SUBNORM_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_W:0]       a_m,
    output logic [EXP_W-1:0]     a_e,
    output logic                 a_s,
    output logic [3:0]           a_cls,
    output logic [MAN_W:0]       b_m,
    output logic [EXP_W-1:0]     b_e,
    output logic                 b_s,
    output logic [3:0]           b_cls
);

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned OP_W   = 4 + 1 + EXP_W + MAN_W + 1;
    localparam int unsigned PAIR_W = 2 * OP_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Decoded operand packed as {cls, s, e, m}
    function automatic logic [OP_W-1:0] decode(input logic [W-1:0] x);
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic [EXP_W-1:0] e_o;
        logic [MAN_W:0]   m_o;
        logic [3:0]       cls;
        s   = x[W-1];
        e   = x[W-2 -: EXP_W];
        f   = x[MAN_W-1:0];
        e_o = e;
        m_o = {1'b1, f};
        cls = 4'b0000;
        if (e == '0) begin
            if (f != '0 && SUBNORM_EN) begin
                m_o = {1'b0, f};
                e_o = EXP_W'(1);
                cls = 4'b0010;
            end else begin
                m_o = '0;
                e_o = '0;
                cls = 4'b0001;
            end
        end else if (&e) begin
            cls = (f == '0) ? 4'b0100 : 4'b1000;
        end
        return {cls, s, e_o, m_o};
    endfunction

    state_t              state_q, state_d;
    logic [PAIR_W-1:0]   out_q, out_d;
    logic [PAIR_W-1:0]   skid_q, skid_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [PAIR_W-1:0]   dec_c;
    logic                accept_c;
    logic                emit_c;

    assign dec_c    = {decode(a), decode(b)};
    assign accept_c = in_valid && in_ready_q;
    assign emit_c   = out_valid_q && out_ready;

    // Skid-buffer next state and data movement
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept_c) begin
                    out_d   = dec_c;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept_c && emit_c) begin
                    out_d = dec_c;
                end else if (accept_c) begin
                    skid_d  = dec_c;
                    state_d = S_FULL;
                end else if (emit_c) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (emit_c) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign {a_cls, a_s, a_e, a_m, b_cls, b_s, b_e, b_m} = out_q;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: decode cases, backpressure, throughput,
// mid-transfer reset and a half-precision / flush-to-zero instance.
module tb_fp_unpack_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid;
    logic [23:0] a_m, b_m;
    logic [7:0]  a_e, b_e;
    logic        a_s, b_s;
    logic [3:0]  a_cls, b_cls;

    logic        nz_in_ready, nz_out_valid;
    logic [23:0] nz_a_m, nz_b_m;
    logic [7:0]  nz_a_e, nz_b_e;
    logic        nz_a_s, nz_b_s;
    logic [3:0]  nz_a_cls, nz_b_cls;

    logic        h_valid;
    logic [15:0] h_a, h_b;
    logic        h_in_ready, h_out_valid;
    logic [10:0] h_a_m, h_b_m;
    logic [4:0]  h_a_e, h_b_e;
    logic        h_a_s, h_b_s;
    logic [3:0]  h_a_cls, h_b_cls;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp_unpack_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a_m(a_m), .a_e(a_e), .a_s(a_s), .a_cls(a_cls),
        .b_m(b_m), .b_e(b_e), .b_s(b_s), .b_cls(b_cls)
    );

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .SUBNORM_EN(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nz_in_ready),
        .a(a), .b(b), .out_valid(nz_out_valid), .out_ready(out_ready),
        .a_m(nz_a_m), .a_e(nz_a_e), .a_s(nz_a_s), .a_cls(nz_a_cls),
        .b_m(nz_b_m), .b_e(nz_b_e), .b_s(nz_b_s), .b_cls(nz_b_cls)
    );

    fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .SUBNORM_EN(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(1'b1),
        .a_m(h_a_m), .a_e(h_a_e), .a_s(h_a_s), .a_cls(h_a_cls),
        .b_m(h_b_m), .b_e(h_b_e), .b_s(h_b_s), .b_cls(h_b_cls)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Normal-number stream used by the backpressure and throughput phases
    function automatic logic [31:0] gen_a(input int i);
        return {1'b0, 8'(16 + i), 23'(3 * i + 1)};
    endfunction
    function automatic logic [31:0] gen_b(input int i);
        return {1'b1, 8'(64 + i), 23'(i)};
    endfunction
    function automatic logic [32:0] exp_a(input int i);
        return {1'b0, 8'(16 + i), 1'b1, 23'(3 * i + 1)};
    endfunction
    function automatic logic [32:0] exp_b(input int i);
        return {1'b1, 8'(64 + i), 1'b1, 23'(i)};
    endfunction

    initial begin
        int acc, emi, first_c, ncyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; h_valid = 1'b0; h_a = '0; h_b = '0;
        #23 rst_n = 1'b1;
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data", 64'({a_m, a_e, b_m, b_cls}), 64'd0);

        // Basic normals, plus half-precision instance in parallel
        in_valid = 1'b1; out_ready = 1'b1;
        a = 32'h3F80_0000; b = 32'hC049_0FDB;
        h_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h7C01;
        step();
        h_valid = 1'b0;
        check("norm_valid", 64'(out_valid), 64'd1);
        check("norm_a", 64'({a_s, a_e, a_m, a_cls}), 64'({1'b0, 8'h7F, 24'h80_0000, 4'h0}));
        check("norm_b", 64'({b_s, b_e, b_m, b_cls}), 64'({1'b1, 8'h80, 24'hC9_0FDB, 4'h0}));
        check("half_a", 64'({h_a_s, h_a_e, h_a_m, h_a_cls}), 64'({1'b0, 5'h0F, 11'h400, 4'h0}));
        check("half_b_cls", 64'(h_b_cls), 64'h8);

        // Signed zero and smallest subnormal
        a = 32'h8000_0000; b = 32'h0000_0001;
        step();
        check("zero_a", 64'({a_s, a_e, a_m, a_cls}), 64'({1'b1, 8'h00, 24'h0, 4'h1}));
        check("sub_b", 64'({b_s, b_e, b_m, b_cls}), 64'({1'b0, 8'h01, 24'h1, 4'h2}));
        check("ftz_b", 64'({nz_b_s, nz_b_e, nz_b_m, nz_b_cls}), 64'({1'b0, 8'h00, 24'h0, 4'h1}));

        // Infinity and NaN
        a = 32'h7F80_0000; b = 32'h7FC0_0000;
        step();
        check("inf_a", 64'({a_s, a_e, a_m, a_cls}), 64'({1'b0, 8'hFF, 24'h80_0000, 4'h4}));
        check("nan_b", 64'({b_s, b_e, b_m, b_cls}), 64'({1'b0, 8'hFF, 24'hC0_0000, 4'h8}));

        // Drain
        in_valid = 1'b0;
        step(); step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: out_ready low, only two pairs fit
        acc = 0; emi = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            logic acc_now;
            in_valid = (acc < 8); a = gen_a(acc); b = gen_b(acc);
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) acc++;
        end
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'({a_s, a_e, a_m}), 64'(exp_a(0)));
        check("bp_hold_b", 64'({b_s, b_e, b_m}), 64'(exp_b(0)));

        out_ready = 1'b1;
        ncyc = 0;
        while (emi < 8 && ncyc < 40) begin
            logic acc_now;
            in_valid = (acc < 8); a = gen_a(acc); b = gen_b(acc);
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_order_a", 64'({a_s, a_e, a_m}), 64'(exp_a(emi)));
                check("bp_order_b", 64'({b_s, b_e, b_m}), 64'(exp_b(emi)));
                emi++;
            end
            step();
            if (acc_now) acc++;
            ncyc++;
        end
        check("bp_emitted", 64'(emi), 64'd8);
        in_valid = 1'b0;
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Throughput: 16 pairs back to back
        acc = 0; emi = 0; first_c = -1;
        for (int c = 0; c < 17; c++) begin
            logic acc_now;
            in_valid = (acc < 16); a = gen_a(8 + acc); b = gen_b(8 + acc);
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                check("tp_data", 64'({a_s, a_e, a_m}), 64'(exp_a(8 + emi)));
                emi++;
            end
            step();
            if (acc_now) acc++;
        end
        check("tp_first", 64'(first_c), 64'd1);
        check("tp_count", 64'(emi), 64'd16);
        in_valid = 1'b0;
        step();

        // Mid-transfer reset from FULL
        out_ready = 1'b0; in_valid = 1'b1; a = gen_a(0); b = gen_b(0);
        step(); step();
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        #3 rst_n = 1'b1;
        step();
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_data", 64'({a_s, a_e, a_m, a_cls, b_s, b_e, b_m, b_cls}), 64'd0);
        out_ready = 1'b1;
        step(); step();
        check("rst2_no_stale", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_unpack_pipe.md
Name: fp_unpack_pipe

Overview:
- Pipelined, parametrised IEEE-754 operand unpacker for the FFT arithmetic datapath (divider/multiplier front end).
- Splits two packed floats A and B into sign, biased exponent, and significand with explicit hidden bit, plus a per-operand class code.
- Valid/ready handshake on both sides; a 2-entry skid buffer sustains full throughput with a registered in_ready.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W
SUBNORM_EN, 1, 1: subnormals unpacked with hidden bit 0 and exponent 1; 0: subnormals flushed to signed zero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept a pair
a  in  W  packed operand A
b  in  W  packed operand B
out_valid  out  1  unpacked pair valid
out_ready  in  1  downstream accepts
a_m  out  MAN_W+1  A significand, hidden bit at MSB
a_e  out  EXP_W  A effective biased exponent
a_s  out  1  A sign
a_cls  out  4  A class {nan,inf,sub,zero}; all zero = normal
b_m, b_e, b_s, b_cls  out  as for A  operand B fields

Behaviour:
- One clock; reset is asynchronous and active-low. All state is updated on posedge clk.
- Reset: out_valid=0, in_ready=1 on deassertion; all data outputs 0; skid entry empty. Asserting reset mid-transfer drops any held data, with no partial output.
- Accept: the pair transfers when in_valid && in_ready. Emit: the pair transfers when out_valid && out_ready.
- Latency: exactly 1 cycle from accept to out_valid when the output register is empty or draining.
- Decode is combinational on input, then registered. Let E = exponent field, F = fraction field.
  - E==0, F==0: m=0, e=0, cls=0001 (zero).
  - E==0, F!=0, SUBNORM_EN=1: m={0,F}, e=1, cls=0010 (sub).
  - E==0, F!=0, SUBNORM_EN=0: m=0, e=0, cls=0001.
  - E==all-ones, F==0: m={1,F}, e=E, cls=0100 (inf).
  - E==all-ones, F!=0: m={1,F}, e=E, cls=1000 (nan).
  - Otherwise: m={1,F}, e=E, cls=0000.
  - Sign always passes through, including zero and NaN.
- Skid buffer, states EMPTY (out reg empty), ONE (out reg full, skid empty), FULL (both full):
  - EMPTY: on accept -> ONE.
  - ONE: accept and no emit -> FULL (new data goes to skid). Accept with emit -> ONE (new data replaces out reg). Emit only -> EMPTY.
  - FULL: in_ready=0. On emit, skid moves to out reg -> ONE.
- in_ready is a registered value, equal to (state != FULL). It never depends combinationally on out_ready.
- Output data is stable while out_valid && !out_ready.
- Ordering is strictly FIFO. No pair is dropped or duplicated.
- Simultaneous accept and emit in ONE gives continuous 1 pair/cycle throughput.

Test Plan:
- Default params, a=0x3F800000, b=0xC0490FDB, out_ready=1 -> next cycle: a_m=0x800000, a_e=0x7F, a_s=0, a_cls=0; b_m=0xC90FDB, b_e=0x80, b_s=1, b_cls=0.
- Specials: a=0x80000000, b=0x00000001 -> a_m=0, a_e=0, a_s=1, a_cls=0001; b_m=0x000001, b_e=1, b_cls=0010. Same b with SUBNORM_EN=0 -> b_m=0, b_cls=0001. a=0x7F800000, b=0x7FC00000 -> a_cls=0100, a_m=0x800000, a_e=0xFF; b_cls=1000, b_m=0xC00000.
- Backpressure: stream 8 pairs with out_ready=0 from cycle 2 -> in_ready falls after 2 accepts; out data is held constant; after out_ready=1, all 8 pairs emerge in order with no loss.
- Throughput: in_valid and out_ready held high for 16 cycles -> 16 outputs in consecutive cycles, first one at cycle 1 after the first accept.
- Reset mid-operation: FULL state, then rst_n pulsed low asynchronously between edges -> out_valid=0 immediately; in_ready=1 and outputs 0 after release; no stale pair emitted.
- Param sweep, EXP_W=5, MAN_W=10 (half precision): a=0x3C00 -> a_m=0x400, a_e=0x0F; a=0x7C01 -> a_cls=1000.
